sub_serial: RTL
===============

// Module: sub_serial
// PURPOSE
//  - Bit-serial N-bit subtractor: diff = a - b - b_in, one bit per clock, LSB first.
//  - Start/done handshake; result and borrow-out are registered and held.
//  - Inverse counterpart of the combinational N-bit adder: same operand and carry/borrow port shape.
//  - Trades latency for a single 1-bit full-subtractor datapath.
// PARAMETERS
//  - N  8  operand and result width in bits (N >= 2).
// PORTS
//  - clk    in   1  single clock; all state changes on its rising edge.
//  - rst_n  in   1  synchronous, active-low reset.
//  - start  in   1  request; accepted only in a cycle where ready=1.
//  - a      in   N  minuend; sampled in the accept cycle only.
//  - b      in   N  subtrahend; sampled in the accept cycle only.
//  - b_in   in   1  borrow-in; sampled in the accept cycle only.
//  - ready  out  1  1 in IDLE, 0 otherwise.
//  - done   out  1  one-cycle pulse; diff/b_out are valid from this cycle on.
//  - diff   out  N  (a - b - b_in) mod 2^N.
//  - b_out  out  1  1 iff a < b + b_in (unsigned).
//  - ovf    out  1  signed overflow flag; present only with SUB_SERIAL_OVF_EN.
// BEHAVIOUR
//  - Reset (rst_n=0 at a clock edge): state=IDLE, ready=1, done=0, diff=0, b_out=0, ovf=0.
//  - Reset mid-operation aborts the operation. No partial result is exposed.
//  - FSM states IDLE, BUSY, DONE.
//    - IDLE & start: load shift registers a_sr<=a, b_sr<=b; borrow<=b_in; cnt<=0; go to BUSY.
//    - IDLE & !start: stay in IDLE.
//    - BUSY: each cycle, d = a_sr[0]^b_sr[0]^borrow.
//    - BUSY: borrow <= (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&borrow).
//    - BUSY: d shifts into the result MSB; a_sr and b_sr shift right; cnt++.
//    - BUSY: on cnt==N-1, go to DONE.
//    - DONE: done=1; diff <= result; b_out <= final borrow; go to IDLE next cycle.
//  - Latency: start accepted at edge k -> done high during cycle k+N+1.
//    - Back-to-back issue throughput: one result every N+2 cycles.
//  - start while BUSY or DONE (ready=0): ignored, with no effect on the operation in flight.
//  - Inputs a, b and b_in may change freely after the accept edge.
//  - diff and b_out hold their value until the next DONE or reset; they are not cleared on the next start.
//  - cnt is $clog2(N) bits wide. It never wraps mid-operation.
//  - Borrow chain is unsigned. Wrap-around is modulo 2^N: 0 - 1 gives all ones with b_out=1.
// CONFIGURATION
//  - Macro SUB_SERIAL_OVF_EN defined:
//    - Port ovf exists; it is registered in DONE alongside diff.
//    - ovf = (a[N-1]!=b[N-1]) & (diff[N-1]!=a[N-1]), using the operands sampled at accept.
//    - The operand MSBs are kept in dedicated flops for this.
//  - Macro undefined: port ovf and its flops are absent. All other behaviour is identical.
// STRUCTURE
//  - Package arith_pkg:
//    - typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} sub_serial_state_t;
//    - no other shared constants.
//  - Sub-module full_subtractor (x, y, b_in -> d, b_out), purely combinational.
//    - Exactly one instance, in the serial datapath.
//  - Top level: FSM, cnt, a_sr, b_sr, result shift register, borrow flop, output registers.
// TESTING (N=8; the bench checks against the behavioural model {b_out,diff} = a - b - b_in)
//  - a=0, b=0, b_in=0 -> diff=0x00, b_out=0; done exactly 9 cycles after the accept edge; ready returns next cycle.
//  - a=5, b=3, b_in=0 -> diff=0x02, b_out=0. Then a=0, b=1 -> diff=0xFF, b_out=1 (wrap).
//  - a=0x80, b=0x7F, b_in=1 -> diff=0x00, b_out=0. With SUB_SERIAL_OVF_EN: ovf=1.
//  - Accept a=10, b=4. Pulse start with a=99 at cycle 3 (BUSY) -> ignored; result diff=0x06.
//  - Accept, then rst_n=0 at cycle 4 -> ready=1, diff=0, b_out=0, done never pulses.
//  - 1000 random a/b/b_in back-to-back -> every result matches the model; 0 errors reported.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared types for the bit-serial subtractor.
package arith_pkg;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} sub_serial_state_t;

endpackage

// File: rtl/sub_serial_if.sv
// Start/done handshake and operand/result bus of the bit-serial subtractor.
// The ovf signal exists only when SUB_SERIAL_OVF_EN is defined.
interface sub_serial_if #(
  parameter int N = 8
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         b_in;
  logic         ready;
  logic         done;
  logic [N-1:0] diff;
  logic         b_out;
`ifdef SUB_SERIAL_OVF_EN
  logic         ovf;
`endif

  modport master (
    output start, a, b, b_in,
`ifdef SUB_SERIAL_OVF_EN
    input  ovf,
`endif
    input  ready, done, diff, b_out
  );

  modport slave (
    input  start, a, b, b_in,
`ifdef SUB_SERIAL_OVF_EN
    output ovf,
`endif
    output ready, done, diff, b_out
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - b_in, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = x ^ y ^ b_in;
  assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial N-bit subtractor: diff = a - b - b_in, LSB first, one bit per clock.
// Start/done handshake; diff and b_out are registered and held until the next
// completion or reset. Defining SUB_SERIAL_OVF_EN adds a registered signed
// overflow flag computed from operand MSBs captured at accept.
module sub_serial
  import arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  sub_serial_if.slave bus
);

  localparam int               CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

  sub_serial_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [N-1:0]      diff_q, diff_d;
  logic              b_out_q, b_out_d;

  logic [N-1:0]      a_sr_q, a_sr_d;
  logic [N-1:0]      b_sr_q, b_sr_d;
  // Holds the N-1 bits already produced; the final bit joins them at completion.
  logic [N-2:0]      res_q, res_d;
  logic [N-1:0]      res_cat;
  logic              borrow_q, borrow_d;

  logic              fs_d, fs_b;

`ifdef SUB_SERIAL_OVF_EN
  logic              a_msb_q, a_msb_d;
  logic              b_msb_q, b_msb_d;
  logic              ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .x     (a_sr_q[0]),
    .y     (b_sr_q[0]),
    .b_in  (borrow_q),
    .d     (fs_d),
    .b_out (fs_b)
  );

  assign res_cat = {fs_d, res_q};

  // Next-state logic: accept in IDLE, one bit per cycle in BUSY, publish in DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    b_out_d  = b_out_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    borrow_d = borrow_q;
`ifdef SUB_SERIAL_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sr_d   = bus.a;
          b_sr_d   = bus.b;
          borrow_d = bus.b_in;
          cnt_d    = '0;
          ready_d  = 1'b0;
          state_d  = S_BUSY;
`ifdef SUB_SERIAL_OVF_EN
          a_msb_d  = bus.a[N-1];
          b_msb_d  = bus.b[N-1];
`endif
        end
      end
      S_BUSY: begin
        res_d    = res_cat[N-1:1];
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        borrow_d = fs_b;
        if (cnt_q == LAST) begin
          // Results are registered on entry to DONE so they are valid with the pulse.
          state_d = S_DONE;
          done_d  = 1'b1;
          diff_d  = res_cat;
          b_out_d = fs_b;
`ifdef SUB_SERIAL_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Control and output registers, cleared by reset (aborts any operation).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      b_out_q <= b_out_d;
`ifdef SUB_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Serial datapath registers; always reloaded at accept, so no reset needed.
  always_ff @(posedge clk) begin
    a_sr_q   <= a_sr_d;
    b_sr_q   <= b_sr_d;
    res_q    <= res_d;
    borrow_q <= borrow_d;
`ifdef SUB_SERIAL_OVF_EN
    a_msb_q  <= a_msb_d;
    b_msb_q  <= b_msb_d;
`endif
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;
  assign bus.b_out = b_out_q;
`ifdef SUB_SERIAL_OVF_EN
  assign bus.ovf   = ovf_q;
`endif

endmodule
